// File: rtl/pwm_audio_pkg.sv
// Shared definitions for the PWM audio output path: sample width, the
// midscale (zero-level) constant and the modulator state encoding.
`timescale 1ns/1ps

package pwm_audio_pkg;

  localparam int SAMPLE_W = 16;

  // Signed zero maps to this offset-binary value; also the sign-flip mask.
  localparam logic [SAMPLE_W-1:0] SAMPLE_MIDSCALE = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } pwm_state_e;

  // Two's complement to offset binary: flipping the sign bit adds midscale.
  function automatic logic [SAMPLE_W-1:0] to_offset_binary(input logic [SAMPLE_W-1:0] s);
    return s ^ SAMPLE_MIDSCALE;
  endfunction

endpackage

// File: rtl/pwm_sample_buf.sv
// Two-entry sample FIFO feeding the PWM modulator. A pop and a push in the
// same cycle are ordered pop-first, so a full buffer still accepts a sample
// on the cycle its head is consumed. flush empties the buffer and a push in
// the same cycle lands in the freshly emptied buffer.
`timescale 1ns/1ps

module pwm_sample_buf
  import pwm_audio_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                push,
  input  logic                pop,
  input  logic [SAMPLE_W-1:0] wr_data,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic [1:0]          count,
  output logic                full,
  output logic                empty
);

  logic [SAMPLE_W-1:0] slot0;
  logic [SAMPLE_W-1:0] slot1;
  logic                do_pop;
  logic                do_push;
  logic [1:0]          base;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign rd_data = slot0;

  // Occupancy after the pop/flush, which decides where (and whether) a push lands.
  always_comb begin
    do_pop  = pop && !empty && !flush;
    base    = flush ? 2'd0 : count - {1'b0, do_pop};
    do_push = push && (base != 2'd2);
  end

  // Occupancy counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= 2'd0;
    else     count <= base + {1'b0, do_push};
  end

  // Sample storage: shift on pop, write at the first free slot on push.
  // NOTE: the data slots carry no reset; count alone says which are valid,
  // so resetting them would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push && base == 2'd0) slot0 <= wr_data;
    else if (do_pop)             slot0 <= slot1;
    if (do_push && base == 2'd1) slot1 <= wr_data;
  end

endmodule

// File: rtl/pwm_modulator.sv
// PWM audio modulator: buffers signed samples in a 2-entry FIFO, converts
// each to a PWM_BITS duty value and plays one sample per 2^PWM_BITS-cycle
// period. Optional feature macro: PWM_DITHER_EN (error-feedback dither of the
// discarded low sample bits); without it the low bits are truncated.
`timescale 1ns/1ps

module pwm_modulator
  import pwm_audio_pkg::*;
#(
  parameter int PWM_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] data_in,
  input  logic        data_in_rdy,
  output logic        sample_req,
  output logic        pwm_out,
  output logic        overrun,
  output logic        underrun
);

  localparam int                  LOW_W    = SAMPLE_W - PWM_BITS;
  localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;
  localparam logic [PWM_BITS-1:0] DUTY_MID = PWM_BITS'(SAMPLE_MIDSCALE >> LOW_W);

  pwm_state_e          state;
  logic [PWM_BITS-1:0] counter;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] duty_trunc;
  logic [PWM_BITS-1:0] duty_next;
  logic [SAMPLE_W-1:0] sample_ob;

  logic [SAMPLE_W-1:0] buf_head;
  logic [1:0]          buf_count;
  logic                buf_full;
  logic                buf_empty;
  logic                push_req;
  logic                load_evt;
  logic                buf_pop;
  logic                buf_flush;

  assign push_req  = data_in_rdy && enable;
  assign load_evt  = enable && ((state == ST_LOAD) ||
                                (state == ST_RUN && counter == CNT_MAX));
  assign buf_pop   = load_evt && !buf_empty;
  assign buf_flush = (state == ST_IDLE);
  assign sample_req = !rst && enable && (buf_count != 2'd2);

  pwm_sample_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .flush   (buf_flush),
    .push    (push_req),
    .pop     (buf_pop),
    .wr_data (data_in),
    .rd_data (buf_head),
    .count   (buf_count),
    .full    (buf_full),
    .empty   (buf_empty)
  );

  assign sample_ob  = to_offset_binary(buf_head);
  assign duty_trunc = PWM_BITS'(sample_ob >> LOW_W);

`ifdef PWM_DITHER_EN
  logic [LOW_W-1:0] acc_q;
  logic [LOW_W-1:0] acc_sum;
  logic             acc_carry;

  // Next duty: truncated duty plus the accumulator carry, saturating at full scale.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    duty_next              = duty_trunc;
    {acc_carry, acc_sum}   = {1'b0, acc_q} + {1'b0, sample_ob[LOW_W-1:0]};
    if (acc_carry && duty_trunc != CNT_MAX) duty_next = duty_trunc + 1'b1;
  end

  // Error accumulator: advances on each sample pop, cleared whenever idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   acc_q <= '0;
    else if (state == ST_IDLE) acc_q <= '0;
    else if (buf_pop)          acc_q <= acc_sum;
  end
`else
  // Next duty: plain truncation of the offset-binary sample.
  always_comb begin
    duty_next = duty_trunc;
  end
`endif

  // Modulator FSM with period counter, duty register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      counter  <= '0;
      duty_q   <= DUTY_MID;
      pwm_out  <= 1'b0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      overrun  <= push_req && buf_full && !buf_pop && !buf_flush;
      underrun <= load_evt && buf_empty;
      if (buf_pop) duty_q <= duty_next;

      case (state)
        ST_IDLE: begin
          counter <= '0;
          pwm_out <= 1'b0;
          if (enable) state <= ST_LOAD;
        end
        ST_LOAD: begin
          counter <= '0;
          pwm_out <= 1'b0;
          state   <= enable ? ST_RUN : ST_IDLE;
        end
        ST_RUN: begin
          if (!enable) begin
            state   <= ST_IDLE;
            counter <= '0;
            pwm_out <= 1'b0;
          end else begin
            counter <= counter + 1'b1;
            pwm_out <= (counter < duty_q);
          end
        end
        default: begin
          state   <= ST_IDLE;
          counter <= '0;
          pwm_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_modulator.sv
// Self-checking bench for pwm_modulator (PWM_BITS = 10). A queue-based model
// of the sample buffer and per-period duty selection predicts each period's
// high count and the per-cycle sample_req/overrun/underrun behaviour.
`timescale 1ns/1ps

module tb_pwm_modulator;

  localparam int PERIOD = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] data_in;
  logic        data_in_rdy;
  logic        sample_req;
  logic        pwm_out;
  logic        overrun;
  logic        underrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [15:0] val;
  } push_t;

  push_t       sched[$];
  logic [15:0] model_q[$];
  int          exp_duty;
  int          dith_acc;

  pwm_modulator #(.PWM_BITS(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .data_in     (data_in),
    .data_in_rdy (data_in_rdy),
    .sample_req  (sample_req),
    .pwm_out     (pwm_out),
    .overrun     (overrun),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  task automatic expect_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  // Period-boundary load: take the oldest sample or report an underrun.
  task automatic model_load(output bit urun);
    int ob;
    int d;
    if (model_q.size() == 0) begin
      urun = 1'b1;
    end else begin
      urun = 1'b0;
      ob   = int'(model_q.pop_front() ^ 16'h8000);
      d    = ob / 64;
`ifdef PWM_DITHER_EN
      dith_acc += ob % 64;
      if (dith_acc >= 64) begin
        dith_acc -= 64;
        if (d < PERIOD - 1) d++;
      end
`endif
      exp_duty = d;
    end
  endtask

  // Reset, idle a few cycles, then enable and step through the LOAD cycle.
  task automatic start_run(input string tag);
    bit ur;
    int idle_bad = 0;
    rst = 1'b1; enable = 1'b0; data_in_rdy = 1'b0; data_in = 16'h0;
    model_q.delete(); sched.delete();
    exp_duty = 512; dith_acc = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (pwm_out !== 1'b0 || sample_req !== 1'b0 || underrun !== 1'b0) idle_bad++;
    end
    expect_int({tag, "_idle_quiet"}, idle_bad, 0);
    enable = 1'b1;
    @(negedge clk);
    expect_int({tag, "_load_enter_underrun"}, int'(underrun), 0);
    @(negedge clk);
    model_load(ur);
    expect_int({tag, "_load_underrun"}, int'(underrun), int'(ur));
    expect_int({tag, "_load_pwm_low"}, int'(pwm_out), 0);
  endtask

  // Play one period, applying scheduled pushes, and compare against the model.
  task automatic measure_period(input string tag, output int highs);
    int          duty0 = exp_duty;
    int          pwm_bad = 0, req_bad = 0, or_bad = 0, ur_bad = 0;
    bit          pend = 1'b0;
    bit          exp_ur, exp_or;
    logic [15:0] pend_val = 16'h0;
    highs = 0;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      exp_ur = 1'b0;
      exp_or = 1'b0;
      if (i == PERIOD - 1) model_load(exp_ur);
      if (pend) begin
        if (model_q.size() >= 2) exp_or = 1'b1;
        else                     model_q.push_back(pend_val);
      end
      if (pwm_out === 1'b1) highs++;
      if (pwm_out !== (i < duty0)) pwm_bad++;
      if (sample_req !== (model_q.size() < 2)) req_bad++;
      if (overrun !== exp_or) or_bad++;
      if (underrun !== exp_ur) ur_bad++;
      pend = 1'b0;
      data_in_rdy = 1'b0;
      foreach (sched[j]) begin
        if (sched[j].cyc == i) begin
          data_in = sched[j].val; data_in_rdy = 1'b1;
          pend = 1'b1; pend_val = sched[j].val;
        end
      end
    end
    data_in_rdy = 1'b0;
    sched.delete();
    expect_int({tag, "_high_count"}, highs, duty0);
    expect_int({tag, "_pwm_shape_errs"}, pwm_bad, 0);
    expect_int({tag, "_sample_req_errs"}, req_bad, 0);
    expect_int({tag, "_overrun_errs"}, or_bad, 0);
    expect_int({tag, "_underrun_errs"}, ur_bad, 0);
  endtask

  task automatic add_push(input int cyc, input logic [15:0] val);
    push_t p;
    p.cyc = cyc; p.val = val;
    sched.push_back(p);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; data_in_rdy = 1'b0; data_in = 16'h0;
    #1;
    expect_int("reset_pwm_out", int'(pwm_out), 0);
    expect_int("reset_sample_req", int'(sample_req), 0);
    expect_int("reset_overrun", int'(overrun), 0);
    expect_int("reset_underrun", int'(underrun), 0);
  endtask

  task automatic test_no_samples();
    int h;
    start_run("nosamp");
    measure_period("nosamp_p1", h);
    expect_int("nosamp_p1_half", h, 512);
    measure_period("nosamp_p2", h);
    expect_int("nosamp_p2_half", h, 512);
  endtask

  task automatic test_extremes();
    int h;
    start_run("ext");
    add_push(10, 16'h7FFF);
    measure_period("ext_p1", h);
    add_push(10, 16'h8000);
    measure_period("ext_p2", h);
    expect_int("ext_full_scale", h, 1023);
    measure_period("ext_p3", h);
    expect_int("ext_zero_scale", h, 0);
  endtask

  task automatic test_overrun();
    int h;
    start_run("ovr");
    add_push(100, 16'h1234);
    add_push(200, 16'hC000);
    add_push(300, 16'h4000);
    measure_period("ovr_p1", h);
    measure_period("ovr_p2", h);
    expect_int("ovr_first_sample", h, 584);
    measure_period("ovr_p3", h);
    expect_int("ovr_second_sample", h, 256);
    measure_period("ovr_p4", h);
    expect_int("ovr_underrun_hold", h, 256);
  endtask

  task automatic test_wrap_push();
    int h;
    start_run("wrap");
    add_push(10, 16'h0000);
    add_push(20, 16'hE000);
    add_push(PERIOD - 2, 16'h2000);
    measure_period("wrap_p1", h);
    expect_int("wrap_buffer_full", int'(sample_req), 0);
    measure_period("wrap_p2", h);
    expect_int("wrap_first", h, 512);
    measure_period("wrap_p3", h);
    expect_int("wrap_second", h, 384);
    measure_period("wrap_p4", h);
    expect_int("wrap_third", h, 640);
  endtask

  task automatic test_random();
    int h;
    start_run("rnd");
    for (int w = 0; w < 5; w++) begin
      int n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++)
        add_push($urandom_range(0, PERIOD - 2), 16'($urandom));
      measure_period($sformatf("rnd_p%0d", w), h);
    end
  endtask

  task automatic test_dither();
    int h[5];
    start_run("dith");
    for (int w = 0; w < 5; w++) begin
      add_push(10, 16'h0020);
      measure_period($sformatf("dith_p%0d", w), h[w]);
    end
`ifdef PWM_DITHER_EN
    expect_int("dith_pair_sum", h[1] + h[2], 1025);
    expect_int("dith_pair_sum2", h[3] + h[4], 1025);
`else
    expect_int("dith_trunc_a", h[1], 512);
    expect_int("dith_trunc_b", h[2], 512);
`endif
  endtask

  task automatic test_rst_mid_and_toggle();
    int h;
    int found = -1;
    start_run("rstmid");
    add_push(5, 16'h7FFF);
    measure_period("rstmid_p1", h);
    repeat (300) @(negedge clk);
    expect_int("rstmid_pwm_high_before", int'(pwm_out), 1);
    #2 rst = 1'b1;
    #1;
    expect_int("rstmid_pwm_async_low", int'(pwm_out), 0);
    expect_int("rstmid_sample_req_low", int'(sample_req), 0);

    start_run("tog");
    add_push(10, 16'h1111);
    add_push(20, 16'h2222);
    measure_period("tog_p1", h);
    enable = 1'b0;
    @(negedge clk);
    expect_int("tog_idle_pwm", int'(pwm_out), 0);
    @(negedge clk);
    enable = 1'b1;
    #1;
    expect_int("tog_fifo_flushed_req", int'(sample_req), 1);
    for (int k = 1; k <= 6 && found < 0; k++) begin
      @(negedge clk);
      if (underrun === 1'b1) found = k;
    end
    expect_int("tog_load_underrun_cycle", found, 2);
  endtask

  initial begin
    test_reset();
    test_no_samples();
    test_extremes();
    test_overrun();
    test_wrap_push();
    test_random();
    test_dither();
    test_rst_mid_and_toggle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_modulator.md
PWM_MODULATOR -- requirements
Module: pwm_modulator

Interface
REQ-001 SHALL have parameter PWM_BITS, default 10, PWM resolution in bits (legal 6..12); period = 2^PWM_BITS clk cycles.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port enable  input  1  run request; low = idle, output silent.
REQ-005 SHALL have port data_in  input  16  signed two's-complement filtered audio sample.
REQ-006 SHALL have port data_in_rdy  input  1  one-cycle strobe: data_in valid this cycle.
REQ-007 SHALL have port sample_req  output  1  high while the sample buffer is not full and enable is high.
REQ-008 SHALL have port pwm_out  output  1  registered PWM audio bit.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse: sample dropped because the buffer was full.
REQ-010 SHALL have port underrun  output  1  one-cycle pulse: period started with an empty buffer.

Function
REQ-011 SHALL hold samples in a 2-entry FIFO; push on data_in_rdy while enable high; pushes ignored while enable low.
REQ-012 SHALL convert a sample to offset binary (data_in XOR 16'h8000); duty = top PWM_BITS bits of that value.
REQ-013 SHALL implement states IDLE, LOAD, RUN: IDLE->LOAD when enable high; LOAD->RUN after exactly one cycle; RUN->IDLE and LOAD->IDLE on the cycle enable is sampled low.
REQ-014 SHALL in LOAD pop the FIFO head into duty_q if non-empty, else keep duty_q and pulse underrun.
REQ-015 SHALL in RUN increment a PWM_BITS-wide counter each cycle, wrapping from 2^PWM_BITS-1 to 0.
REQ-016 SHALL in RUN, on the cycle the counter equals 2^PWM_BITS-1, load duty_q as in REQ-014, effective from counter value 0.
REQ-017 SHALL register pwm_out = (counter < duty_q) with one cycle of latency; duty 0 gives constant low, duty 2^PWM_BITS-1 gives high 2^PWM_BITS-1 cycles per period.
REQ-018 SHALL, on simultaneous push and pop with the FIFO full, pop first then accept the push, with no overrun.
REQ-019 SHALL, on push with the FIFO full and no pop, discard the new sample, keep stored entries, and pulse overrun.
REQ-020 SHALL, in IDLE, hold counter 0, pwm_out 0, and flush the FIFO.
REQ-021 SHALL deassert sample_req in the same cycle the FIFO reaches 2 entries.

Reset
REQ-022 SHALL, on rst, immediately force state IDLE, counter 0, FIFO empty, duty_q = 2^(PWM_BITS-1), and pwm_out, sample_req, overrun and underrun all 0.
REQ-023 SHALL, on rst deassertion with enable high, pass through LOAD before emitting any PWM pulse.

Configuration
REQ-024 SHALL, with PWM_DITHER_EN defined, add the discarded low (16-PWM_BITS) bits into an error accumulator at each duty load; a carry increments duty, saturating at 2^PWM_BITS-1. The accumulator clears on rst and in IDLE.
REQ-025 SHALL, without PWM_DITHER_EN, truncate the discarded bits and contain no accumulator logic.

Structure
REQ-026 SHALL keep the state enum, the midscale constant and the 16-bit sample width constant in shared package pwm_audio_pkg.
REQ-027 SHALL implement the 2-entry FIFO as sub-module pwm_sample_buf (push, pop, data, count/full/empty).

Verification (PWM_BITS = 10)
REQ-028 SHALL cover: reset, enable=1, no samples -> underrun pulse at each period load; pwm_out high 512 of 1024 cycles.
REQ-029 SHALL cover: push 16'h7FFF -> next period high 1023 of 1024 cycles; push 16'h8000 -> following period constant low.
REQ-030 SHALL cover: three pushes within one period -> sample_req low after the second push; third push gives an overrun pulse; periods then play samples 1 and 2 in order.
REQ-031 SHALL cover: push on exactly the wrap cycle with the FIFO full -> no overrun, FIFO count stays 2.
REQ-032 SHALL cover: repeated 16'h0020 (discarded bits = half LSB) -> with PWM_DITHER_EN, duty alternates 512/513; without it, constant 512.
REQ-033 SHALL cover: rst asserted mid-period with pwm_out high -> pwm_out 0 before the next clk edge; enable toggled low then high -> FIFO empty, LOAD reports underrun.
